// File: rtl/dump_pkg.sv
// Shared types and helpers for the state dump scanner.
//   scan_mode_e   : selects which read port a scan walks (register bank or data memory).
//   scan_state_e  : scanner FSM states.
//   bound_rd_lat  : clamps a requested read latency into the supported 1..3 range.
package dump_pkg;

    typedef enum logic {
        SCAN_REGS = 1'b0,
        SCAN_MEM  = 1'b1
    } scan_mode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        EMIT   = 3'd3,
        FINISH = 3'd4
    } scan_state_e;

    function automatic int bound_rd_lat(input int lat);
        if (lat < 1) begin
            return 1;
        end
        if (lat > 3) begin
            return 3;
        end
        return lat;
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Little-endian byte-to-word assembler.
// Bytes are shifted in from the top lane downwards, so after BYTES accepted
// bytes the first byte received sits in bits [7:0].
// Ports:
//   clk     : clock
//   rst     : synchronous active-low reset
//   i_clr   : empties the assembler (wins over i_valid)
//   i_valid : i_byte carries a new byte this cycle
//   i_byte  : incoming byte
//   o_word  : assembled word
//   o_full  : BYTES bytes have been collected; further bytes are dropped
module byte_word_assembler
    import dump_pkg::*;
#(
    parameter int BYTES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_valid,
    input  logic [7:0]           i_byte,
    output logic [8*BYTES-1:0]   o_word,
    output logic                 o_full
);

    localparam int CW = $clog2(BYTES + 1);

    logic [CW-1:0] r_cnt;
    logic [7:0]    r_lane [BYTES];
    logic          w_shift;

    assign o_full  = (r_cnt == CW'(BYTES));
    assign w_shift = i_valid && !o_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] w_in;
            // Top lane takes the new byte; every other lane takes its upper neighbour.
            if (gi == BYTES - 1) begin : g_top
                assign w_in = i_byte;
            end else begin : g_mid
                assign w_in = r_lane[gi + 1];
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_lane[gi] <= '0;
                end else if (i_clr) begin
                    r_lane[gi] <= '0;
                end else if (w_shift) begin
                    r_lane[gi] <= w_in;
                end
            end

            assign o_word[8*gi +: 8] = r_lane[gi];
        end
    endgenerate

endmodule

// File: rtl/state_dump_scanner.sv
// State dump scanner: on start, walks the register bank or the byte-addressed
// data memory through their secondary read ports and streams one word per beat
// over a valid/ready interface, then pulses done.
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   start, mode           : begin a scan (IDLE only); 0 = registers, 1 = data memory
//   base_addr, count      : first byte address / register index, number of words
//   abort                 : cancel the scan in progress
//   mem_rd_en/mem_addr    : data-memory byte read port, mem_rd_data returns RD_LAT later
//   reg_rd_en/reg_addr    : register read port, reg_rd_data returns RD_LAT later
//   out_valid/out_ready   : output handshake; out_data/out_index/out_last qualify it
//   busy, done            : scan in progress, one-cycle completion pulse
module state_dump_scanner
    import dump_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int BYTES  = DATA_W / 8,
    parameter int MEM_AW = 10,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [MEM_AW-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              reg_rd_en,
    output logic [REG_AW-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int LAT  = bound_rd_lat(RD_LAT);
    localparam int BC_W = $clog2(BYTES) + 1;

    scan_state_e       r_state;
    scan_state_e       w_state_next;
    scan_mode_e        r_mode;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_word_idx;
    logic [MEM_AW-1:0] r_addr;
    logic [REG_AW-1:0] r_reg_idx;
    logic [BC_W-1:0]   r_byte_cnt;
    logic [DATA_W-1:0] r_reg_word;
    logic [DATA_W-1:0] r_out_data;
    logic              r_reg_got;
    logic [LAT-1:0]    r_lat_pipe;

    logic              w_abort;
    logic              w_start_go;
    logic              w_strobe;
    logic              w_ret;
    logic              w_accept;
    logic              w_last;
    logic              w_word_ready;
    logic              w_asm_clr;
    logic              w_asm_valid;
    logic              w_asm_full;
    logic [DATA_W-1:0] w_asm_word;

    assign w_abort    = abort && (r_state != IDLE);
    assign w_start_go = start && (r_state == IDLE);
    // A strobe is suppressed in the abort cycle so nothing new goes in flight.
    assign w_strobe   = (r_state == ISSUE) && !abort;
    // The pipe tail marks the cycle in which a read strobed LAT cycles ago returns.
    assign w_ret      = r_lat_pipe[LAT-1];
    assign w_accept   = (r_state == EMIT) && out_ready;
    assign w_last     = (r_word_idx == r_count - 1'b1);
    assign w_word_ready = (r_mode == SCAN_MEM) ? w_asm_full : r_reg_got;

    assign w_asm_valid = w_ret && (r_mode == SCAN_MEM);
    assign w_asm_clr   = w_start_go || w_accept || w_abort;

    byte_word_assembler #(
        .BYTES (BYTES)
    ) u_asm (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_asm_clr),
        .i_valid (w_asm_valid),
        .i_byte  (mem_rd_data),
        .o_word  (w_asm_word),
        .o_full  (w_asm_full)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (count == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (r_mode == SCAN_REGS || r_byte_cnt == BC_W'(BYTES - 1)) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (w_word_ready) begin
                    w_state_next = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    w_state_next = w_last ? FINISH : ISSUE;
                end
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        // Abort beats any other transition, including a simultaneous accept.
        if (w_abort) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Read-latency tracker; flushing it on abort makes late returns invisible.
    always_ff @(posedge clk) begin
        if (!rst || w_abort) begin
            r_lat_pipe <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                r_lat_pipe[i] <= r_lat_pipe[i-1];
            end
            r_lat_pipe[0] <= w_strobe;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode     <= SCAN_REGS;
            r_count    <= '0;
            r_word_idx <= '0;
            r_addr     <= '0;
            r_reg_idx  <= '0;
            r_byte_cnt <= '0;
            r_reg_word <= '0;
            r_reg_got  <= 1'b0;
            r_out_data <= '0;
        end else begin
            if (w_start_go) begin
                r_mode     <= scan_mode_e'(mode);
                r_count    <= count;
                r_addr     <= base_addr;
                r_reg_idx  <= base_addr[REG_AW-1:0];
                r_word_idx <= '0;
                r_byte_cnt <= '0;
                r_reg_got  <= 1'b0;
            end
            // The byte address simply keeps counting across words and wraps naturally.
            if (w_strobe && r_mode == SCAN_MEM) begin
                r_addr     <= r_addr + 1'b1;
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
            if (w_ret && r_mode == SCAN_REGS) begin
                r_reg_word <= (r_reg_idx == '0) ? '0 : reg_rd_data;
                r_reg_got  <= 1'b1;
            end
            // Single output buffer: loaded once per word, held through any stall.
            if (r_state == WAIT && w_word_ready && !w_abort) begin
                r_out_data <= (r_mode == SCAN_MEM) ? w_asm_word : r_reg_word;
            end
            if (w_accept && !w_abort && !w_last) begin
                r_word_idx <= r_word_idx + 1'b1;
                r_reg_idx  <= r_reg_idx + 1'b1;
                r_byte_cnt <= '0;
                r_reg_got  <= 1'b0;
            end
        end
    end

    assign mem_rd_en = w_strobe && (r_mode == SCAN_MEM);
    assign reg_rd_en = w_strobe && (r_mode == SCAN_REGS);
    assign mem_addr  = r_addr;
    assign reg_addr  = r_reg_idx;
    assign out_valid = (r_state == EMIT);
    assign out_data  = r_out_data;
    assign out_index = r_word_idx;
    assign out_last  = (r_state == EMIT) && w_last;
    assign busy      = (r_state == ISSUE) || (r_state == WAIT) || (r_state == EMIT);
    assign done      = (r_state == FINISH);

endmodule

// File: tb/tb_state_dump_scanner.sv
module tb_state_dump_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic        mode = 1'b0;
    logic [5:0]  base_addr = '0;
    logic [7:0]  count = '0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;

    logic        mem_rd_en_a, reg_rd_en_a, out_valid_a, out_last_a, busy_a, done_a;
    logic [5:0]  mem_addr_a;
    logic [4:0]  reg_addr_a;
    logic [7:0]  mem_rd_data_a, out_index_a;
    logic [63:0] reg_rd_data_a, out_data_a;

    logic        mem_rd_en_b, reg_rd_en_b, out_valid_b, out_last_b, busy_b, done_b;
    logic [5:0]  mem_addr_b;
    logic [4:0]  reg_addr_b;
    logic [7:0]  mem_rd_data_b, out_index_b;
    logic [63:0] out_data_b;
    logic [7:0]  d0_b, d1_b;

    logic [7:0]  mem [64];

    typedef struct {
        logic [63:0] data;
        logic [7:0]  idx;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    logic [5:0]  addr_log[$];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    state_dump_scanner #(
        .DATA_W(64), .MEM_AW(6), .REG_AW(5), .CNT_W(8), .RD_LAT(1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
        .count(count), .abort(abort), .mem_rd_en(mem_rd_en_a), .mem_addr(mem_addr_a),
        .mem_rd_data(mem_rd_data_a), .reg_rd_en(reg_rd_en_a), .reg_addr(reg_addr_a),
        .reg_rd_data(reg_rd_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_index(out_index_a), .out_last(out_last_a),
        .busy(busy_a), .done(done_a)
    );

    state_dump_scanner #(
        .DATA_W(64), .MEM_AW(6), .REG_AW(5), .CNT_W(8), .RD_LAT(3)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode), .base_addr(base_addr),
        .count(count), .abort(abort), .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b),
        .mem_rd_data(mem_rd_data_b), .reg_rd_en(reg_rd_en_b), .reg_addr(reg_addr_b),
        .reg_rd_data(64'h0), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_index(out_index_b), .out_last(out_last_b),
        .busy(busy_b), .done(done_b)
    );

    // Read-port models: one registered stage for A, three for B.
    always @(posedge clk) begin
        mem_rd_data_a <= mem[mem_addr_a];
        reg_rd_data_a <= (reg_addr_a == 5'd0) ? 64'hDEAD : 64'(reg_addr_a) * 64'h10;
        d0_b          <= mem[mem_addr_b];
        d1_b          <= d0_b;
        mem_rd_data_b <= d1_b;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the current point until out_valid of A, logging strobed addresses.
    task automatic wait_valid_a(output int lat);
        lat = 0;
        addr_log.delete();
        while (!out_valid_a && lat < 60) begin
            if (mem_rd_en_a) addr_log.push_back(mem_addr_a);
            tick();
            lat++;
        end
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        while (!done_a && n < 200) begin
            tick();
            n++;
        end
        chk(name, {63'd0, done_a}, 64'd1);
    endtask

    task automatic go(input logic m, input logic [5:0] b, input logic [7:0] c);
        mode = m;
        base_addr = b;
        count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int stall_strobes;
        int stall_changes;
        int seen;
        logic [63:0] held;
        logic [5:0] wrap_exp [8];

        for (int i = 0; i < 64; i++) mem[i] = 8'(i + 1);
        wrap_exp = '{6'h3C, 6'h3D, 6'h3E, 6'h3F, 6'h00, 6'h01, 6'h02, 6'h03};

        // Scoreboard monitor: pops one expectation per accepted beat of A.
        fork
            forever begin
                @(negedge clk);
                if (rst && out_valid_a && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        beat_t e;
                        e = sb.pop_front();
                        $display("[TB] beat idx=%0d data=%h last=%0d", out_index_a, out_data_a, out_last_a);
                        chk("beat_data", out_data_a, e.data);
                        chk("beat_index", {56'd0, out_index_a}, {56'd0, e.idx});
                        chk("beat_last", {63'd0, out_last_a}, {63'd0, e.last});
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("rst_out_data", out_data_a, 64'd0);
        chk("rst_out_index", {56'd0, out_index_a}, 64'd0);
        chk("rst_flags", {58'd0, busy_a, done_a, out_last_a, mem_rd_en_a, reg_rd_en_a, busy_b}, 64'd0);
        rst = 1'b1;
        tick();

        // Data mode, one word
        sb.push_back('{64'h0807060504030201, 8'd0, 1'b1});
        go(1'b1, 6'd0, 8'd1);
        chk("s1_busy", {63'd0, busy_a}, 64'd1);
        wait_valid_a(lat);
        chk("s1_latency", 64'(lat), 64'd10);
        tick();
        chk("s1_done", {62'd0, done_a, busy_a}, 64'b10);
        tick();
        chk("s1_done_pulse", {63'd0, done_a}, 64'd0);
        $display("[TB] scan data count=1 latency=%0d", lat);

        // Register mode, five words, index 0 forced to zero
        for (int i = 0; i < 5; i++) sb.push_back('{64'(i) * 64'h10, 8'(i), (i == 4)});
        go(1'b0, 6'd0, 8'd5);
        wait_valid_a(lat);
        chk("s2_latency", 64'(lat), 64'd3);
        wait_done_a("s2_done");
        chk("s2_sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] scan regs count=5");
        tick();

        // Backpressure on beat 0 of a 3-word data scan, with an ignored start
        out_ready = 1'b0;
        sb.push_back('{64'h0807060504030201, 8'd0, 1'b0});
        sb.push_back('{64'h100F0E0D0C0B0A09, 8'd1, 1'b0});
        sb.push_back('{64'h1817161514131211, 8'd2, 1'b1});
        go(1'b1, 6'd0, 8'd3);
        wait_valid_a(lat);
        held = out_data_a;
        stall_strobes = 0;
        stall_changes = 0;
        for (int i = 0; i < 7; i++) begin
            start = (i == 3);
            if (i == 3) begin
                mode = 1'b0;
                count = 8'd2;
            end
            tick();
            start = 1'b0;
            mode = 1'b1;
            if (mem_rd_en_a || reg_rd_en_a) stall_strobes++;
            if (out_data_a !== held || !out_valid_a || out_index_a != 8'd0) stall_changes++;
        end
        chk("s3_stall_strobes", 64'(stall_strobes), 64'd0);
        chk("s3_stall_stable", 64'(stall_changes), 64'd0);
        out_ready = 1'b1;
        wait_done_a("s3_done");
        chk("s3_sb_empty", 64'(sb.size()), 64'd0);
        tick();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid_a || busy_a || reg_rd_en_a) seen++;
            tick();
        end
        chk("s5_start_ignored", 64'(seen), 64'd0);
        $display("[TB] scan data count=3 with stall");

        // count = 0
        go(1'b1, 6'd0, 8'd0);
        chk("s4_done", {60'd0, done_a, busy_a, out_valid_a, mem_rd_en_a}, 64'b1000);
        tick();
        chk("s4_done_pulse", {63'd0, done_a}, 64'd0);
        $display("[TB] scan count=0");

        // Abort during WAIT, then a fresh scan
        go(1'b1, 6'd0, 8'd1);
        repeat (8) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s6_abort_idle", {61'd0, busy_a, out_valid_a, done_a}, 64'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid_a || done_a || busy_a) seen++;
            tick();
        end
        chk("s6_abort_quiet", 64'(seen), 64'd0);
        sb.push_back('{64'h100F0E0D0C0B0A09, 8'd0, 1'b1});
        go(1'b1, 6'd8, 8'd1);
        wait_done_a("s6_restart_done");
        chk("s6_sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] abort then rescan");
        tick();

        // Address wrap-around
        sb.push_back('{64'h04030201403F3E3D, 8'd0, 1'b1});
        go(1'b1, 6'h3C, 8'd1);
        wait_valid_a(lat);
        chk("s7_strobe_count", 64'(addr_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
            chk("s7_addr", {58'd0, addr_log[i]}, {58'd0, wrap_exp[i]});
        end
        wait_done_a("s7_done");
        chk("s7_sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] scan wrap base=0x3C");
        tick();

        // RD_LAT = 3 instance
        mode = 1'b1;
        base_addr = 6'd0;
        count = 8'd1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        lat = 0;
        while (!out_valid_b && lat < 60) begin
            tick();
            lat++;
        end
        chk("s8_latency", 64'(lat), 64'd12);
        chk("s8_data", out_data_b, 64'h0807060504030201);
        chk("s8_index_last", {55'd0, out_index_b, out_last_b}, 64'd1);
        tick();
        chk("s8_done", {62'd0, done_b, busy_b}, 64'b10);
        $display("[TB] scan data RD_LAT=3 latency=%0d", lat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
